mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, meaning data/address width.
REQ-002 SHALL have parameter MEM_LATENCY, default 2, meaning cycles readM/writeM are held per access (legal 1..15).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, meaning synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 SHALL have ports i_req in 1, i_addr in WORD_SIZE, i_rdata out WORD_SIZE, i_done out 1, meaning the instruction-fetch requester (read-only).
REQ-006 SHALL have ports d_req in 1, d_we in 1, d_addr in WORD_SIZE, d_wdata in WORD_SIZE, d_rdata out WORD_SIZE, d_done out 1, meaning the data requester.
REQ-007 SHALL have ports readM out 1, writeM out 1, address out WORD_SIZE, data inout WORD_SIZE, meaning the shared single-port memory bus.

Function
REQ-008 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-009 SHALL, in IDLE with any req high at the clock edge, latch the winner's address, write enable and write data, select the winner, and enter ACCESS.
REQ-010 SHALL remain in ACCESS exactly MEM_LATENCY cycles, holding readM (read) or writeM (write) high and address stable throughout.
REQ-011 SHALL drive data with latched write data only while writeM is high; otherwise data SHALL be high-impedance.
REQ-012 SHALL capture data into the winner's rdata register on the last ACCESS edge for reads; rdata holds until that requester's next read completes.
REQ-013 SHALL, in DONE, assert the winner's done for exactly one cycle, then return to IDLE unconditionally.
REQ-014 SHALL give a request sampled at edge N readM/writeM in cycles N+1..N+MEM_LATENCY and done in cycle N+MEM_LATENCY+1.
REQ-015 SHALL require requesters to hold req and request fields stable until done; req still high in the IDLE following DONE is treated as a new request.
REQ-016 SHALL, when both req are high in IDLE, grant per REQ-022; the loser is serviced next, with no request dropped.
REQ-017 SHALL ignore req changes during ACCESS and DONE; the latched transaction completes unaltered.
REQ-018 SHALL never assert readM and writeM together, nor i_done and d_done together.

Reset
REQ-019 SHALL, on reset_n low at an edge, go to IDLE with readM=0, writeM=0, address=0, data=Z, i_done=0, d_done=0, i_rdata=0, d_rdata=0, latency counter=0, round-robin pointer=data.
REQ-020 SHALL, on reset mid-ACCESS or mid-DONE, abort without a done pulse and with no rdata update.

Configuration
REQ-021 SHALL provide macro MEM_ARB_FAIR_EN.
REQ-022 SHALL, with MEM_ARB_FAIR_EN defined, arbitrate round-robin (pointer flips to the other requester after each grant); without it, data SHALL always win over fetch.

Structure
REQ-023 SHALL place the FSM state enum, WORD_SIZE and the requester-select encoding in shared package mem_arb_pkg.
REQ-024 SHALL implement the ACCESS cycle count in one sub-module, lat_counter (load, decrement, zero flag).

Verification (MEM_LATENCY=2)
REQ-025 SHALL check: i_req, i_addr=0x0010, mem[0x10]=0x6000 at edge 0 -> readM high in cycles 1-2 with address=0x0010, i_done in cycle 3, i_rdata=0x6000.
REQ-026 SHALL check: d_req, d_we=1, d_addr=0x0020, d_wdata=0xBEEF -> writeM for 2 cycles with data=0xBEEF, d_done in cycle 3, mem[0x20]=0xBEEF, data=Z afterwards.
REQ-027 SHALL check: both req high together, without macro -> data served first, fetch second, d_done cycle 3, i_done cycle 7.
REQ-028 SHALL check: with MEM_ARB_FAIR_EN, four back-to-back simultaneous requests -> grant order data, fetch, data, fetch.
REQ-029 SHALL check: reset_n low in the 2nd ACCESS cycle -> next edge readM=writeM=0, no done, rdata=0, IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the two-requester memory arbiter:
//   WORD_SIZE : default data/address width
//   state_e   : arbiter FSM states (IDLE, ACCESS, DONE)
//   sel_e     : requester-select encoding (fetch / data)
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int WORD_SIZE = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef enum logic {
    SEL_I = 1'b0,   // instruction-fetch requester
    SEL_D = 1'b1    // data requester
  } sel_e;

endpackage

// File: rtl/mem_arbiter_lat_counter.sv
// ---------------------------------------------------------------------------
// lat_counter
// Down-counter timing the ACCESS phase of one memory transaction.
// Ports:
//   clk        : clock, rising edge
//   reset_n    : synchronous active-low reset (count -> 0)
//   i_load     : load i_load_val (has priority over decrement)
//   i_load_val : value loaded on i_load
//   i_dec      : decrement by one; ignored when the count is already zero
//   o_zero     : count is zero
// ---------------------------------------------------------------------------
module lat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Arbitrates an instruction-fetch port (read-only) and a data port (read /
// write) onto one shared single-port memory bus. Each access holds
// readM/writeM for MEM_LATENCY cycles, then pulses the winner's done for one
// cycle. A request sampled at edge N sees the strobe in cycles
// N+1..N+MEM_LATENCY and done in cycle N+MEM_LATENCY+1.
//
// Parameters:
//   WORD_SIZE   : data/address width
//   MEM_LATENCY : cycles each access is held on the bus (1..15)
// Ports:
//   clk, reset_n                    : clock, synchronous active-low reset
//   i_req, i_addr, i_rdata, i_done  : instruction-fetch requester
//   d_req, d_we, d_addr, d_wdata,
//   d_rdata, d_done                 : data requester
//   readM, writeM, address, data    : shared memory bus (data is inout)
//
// Build option:
//   MEM_ARB_FAIR_EN : round-robin arbitration when both requesters contend
//                     (pointer starts at data). Undefined: data always wins.
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int WORD_SIZE   = mem_arb_pkg::WORD_SIZE,
  parameter int MEM_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  // instruction fetch
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic                 i_done,
  // data
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_done,
  // memory bus
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data
);

  import mem_arb_pkg::*;

  localparam int         CNT_W    = 4;
  localparam logic [3:0] LOAD_VAL = 4'(MEM_LATENCY - 1);

  state_e               r_state;
  state_e               w_next;
  sel_e                 r_sel;
  sel_e                 w_win;
  logic                 r_we;
  logic [WORD_SIZE-1:0] r_addr;
  logic [WORD_SIZE-1:0] r_wdata;
  logic [WORD_SIZE-1:0] r_i_rdata;
  logic [WORD_SIZE-1:0] r_d_rdata;
  logic                 w_grant;
  logic                 w_dec;
  logic                 w_zero;
  logic                 w_capture;
  logic                 w_readM;
  logic                 w_writeM;

  // Arbitration: who wins when the FSM is idle and at least one req is up.
`ifdef MEM_ARB_FAIR_EN
  sel_e r_ptr;

  // Pointer names the requester that wins the next contended grant; after
  // every grant it moves to whoever did not win.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ptr <= SEL_D;
    end else if (w_grant) begin
      r_ptr <= (w_win == SEL_D) ? SEL_I : SEL_D;
    end
  end

  always_comb begin
    w_win = SEL_I;
    if (i_req && d_req) begin
      w_win = r_ptr;
    end else if (d_req) begin
      w_win = SEL_D;
    end
  end
`else
  always_comb begin
    w_win = SEL_I;
    if (d_req) begin
      w_win = SEL_D;
    end
  end
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next state and per-cycle controls
  always_comb begin
    w_next    = r_state;
    w_grant   = 1'b0;
    w_dec     = 1'b0;
    w_capture = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_req || d_req) begin
          w_grant = 1'b1;
          w_next  = ACCESS;
        end
      end
      ACCESS: begin
        // Counter was loaded with MEM_LATENCY-1, so reaching zero marks the
        // final ACCESS cycle; read data is taken on that edge.
        if (w_zero) begin
          w_capture = !r_we;
          w_next    = DONE;
        end else begin
          w_dec = 1'b1;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  lat_counter #(
    .CNT_W (CNT_W)
  ) u_lat_counter (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_grant),
    .i_load_val (LOAD_VAL),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  // Transaction latch and read-data return registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sel     <= SEL_D;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      if (w_grant) begin
        r_sel   <= w_win;
        r_we    <= (w_win == SEL_D) ? d_we : 1'b0;
        r_addr  <= (w_win == SEL_D) ? d_addr : i_addr;
        r_wdata <= d_wdata;
      end
      if (w_capture) begin
        if (r_sel == SEL_I) begin
          r_i_rdata <= data;
        end else begin
          r_d_rdata <= data;
        end
      end
    end
  end

  assign w_readM  = (r_state == ACCESS) && !r_we;
  assign w_writeM = (r_state == ACCESS) && r_we;

  assign readM   = w_readM;
  assign writeM  = w_writeM;
  assign address = r_addr;
  assign data    = w_writeM ? r_wdata : {WORD_SIZE{1'bz}};
  assign i_done  = (r_state == DONE) && (r_sel == SEL_I);
  assign d_done  = (r_state == DONE) && (r_sel == SEL_D);
  assign i_rdata = r_i_rdata;
  assign d_rdata = r_d_rdata;

endmodule
